// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel clock-enable and four test patterns.
// Define VGA_BORDER_EN to force a one-pixel white frame around the active area.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int COLOR_W    = 4,
    parameter int CHECK_LOG2 = 5,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW        = $clog2(H_TOTAL),
    localparam int YW        = $clog2(V_TOTAL)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   pix_en,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic [XW-1:0]          x,
    output logic [YW-1:0]          y,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b
);

    localparam int HAW = $clog2(H_ACTIVE);
    localparam int VAW = $clog2(V_ACTIVE);
    localparam int CW3 = 3 * COLOR_W;

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic          HS_LVL   = 1'(HS_POL);
    localparam logic          VS_LVL   = 1'(VS_POL);

    logic [XW-1:0]      r_h_cnt;
    logic [YW-1:0]      r_v_cnt;
    logic [7:0]         r_frame_cnt;
    logic [1:0]         r_mode_q;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_line_start;
    logic               r_frame_start;
    logic [CW3-1:0]     r_rgb;

    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_frame_wrap;
    logic               w_de;
    logic               w_hs_on;
    logic               w_vs_on;
    logic [XW+2:0]      w_bar_full;
    logic [2:0]         w_bar;
    logic [2:0]         w_bar_code;
    logic [CW3-1:0]     w_bar_rgb;
    logic               w_check;
    logic [XW+COLOR_W-1:0] w_h_ext;
    logic [YW+COLOR_W-1:0] w_v_ext;
    logic [COLOR_W-1:0] w_grad_r;
    logic [COLOR_W-1:0] w_grad_g;
    logic [CW3-1:0]     w_pat;
    logic [CW3-1:0]     w_rgb;

    assign w_h_wrap     = (r_h_cnt == H_LAST);
    assign w_v_wrap     = (r_v_cnt == V_LAST);
    assign w_frame_wrap = w_h_wrap && w_v_wrap;
    assign w_de         = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_on      = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    assign w_vs_on      = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

    // Bar index is a constant divide; only meaningful while h is in the active range.
    assign w_bar_full = ((XW+3)'(r_h_cnt) << 3) / (XW+3)'(H_ACTIVE);
    assign w_bar      = w_bar_full[2:0];

    always_comb begin
        w_bar_code = 3'b000;
        case (w_bar)
            3'd0:    w_bar_code = 3'b111;
            3'd1:    w_bar_code = 3'b110;
            3'd2:    w_bar_code = 3'b011;
            3'd3:    w_bar_code = 3'b010;
            3'd4:    w_bar_code = 3'b101;
            3'd5:    w_bar_code = 3'b100;
            3'd6:    w_bar_code = 3'b001;
            default: w_bar_code = 3'b000;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bar_chan
            assign w_bar_rgb[gi*COLOR_W +: COLOR_W] = {COLOR_W{w_bar_code[gi]}};
        end
    endgenerate

    assign w_check = r_h_cnt[CHECK_LOG2] ^ r_v_cnt[CHECK_LOG2];

    // Top COLOR_W bits of the active-range width; narrow ranges are zero-padded below.
    assign w_h_ext  = (XW+COLOR_W)'(r_h_cnt) << COLOR_W;
    assign w_v_ext  = (YW+COLOR_W)'(r_v_cnt) << COLOR_W;
    assign w_grad_r = COLOR_W'(w_h_ext >> HAW);
    assign w_grad_g = COLOR_W'(w_v_ext >> VAW);

    always_comb begin
        w_pat = '0;
        case (r_mode_q)
            2'd0:    w_pat = solid_rgb;
            2'd1:    w_pat = w_bar_rgb;
            2'd2:    w_pat = {CW3{w_check}};
            default: w_pat = {w_grad_r, w_grad_g, COLOR_W'(r_frame_cnt)};
        endcase
    end

`ifdef VGA_BORDER_EN
    logic w_border;
    assign w_border = (r_h_cnt == '0) || (r_h_cnt == H_ACT - 1'b1) ||
                      (r_v_cnt == '0) || (r_v_cnt == V_ACT - 1'b1);
    assign w_rgb    = !w_de ? '0 : (w_border ? '1 : w_pat);
`else
    assign w_rgb    = w_de ? w_pat : '0;
`endif

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_cnt   <= '0;
            r_mode_q      <= '0;
            r_hsync       <= ~HS_LVL;
            r_vsync       <= ~VS_LVL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else if (pix_en) begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
            end
            // New mode takes effect only from pixel (0,0) of the next frame.
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_mode_q    <= mode;
            end
            r_hsync       <= w_hs_on ? HS_LVL : ~HS_LVL;
            r_vsync       <= w_vs_on ? VS_LVL : ~VS_LVL;
            r_de          <= w_de;
            r_x           <= r_h_cnt;
            r_y           <= r_v_cnt;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_frame_wrap;
            r_rgb         <= w_rgb;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign r           = r_rgb[3*COLOR_W-1 -: COLOR_W];
    assign g           = r_rgb[2*COLOR_W-1 -: COLOR_W];
    assign b           = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 24x12 total / 16x8 active timing.
// Output vector layout: {hsync,vsync,de,x[4:0],y[3:0],line_start,frame_start,r,g,b}.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        pix_en;
    logic [1:0]  mode;
    logic [11:0] solid_rgb;
    logic        hsync, vsync, de, line_start, frame_start;
    logic [4:0]  x;
    logic [3:0]  y;
    logic [3:0]  r, g, b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .COLOR_W(4), .CHECK_LOG2(1)
    ) dut (
        .clk(clk), .n_rst(n_rst), .pix_en(pix_en), .mode(mode), .solid_rgb(solid_rgb),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .r(r), .g(g), .b(b)
    );

    logic [25:0] got;
    assign got = {hsync, vsync, de, x, y, line_start, frame_start, r, g, b};

    localparam logic [11:0] BAR [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                        12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic [25:0] expv;
    int ph, pv, fc, mq, cyc;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [11:0] exp_rgb(int h, int v, int m, int f, logic [11:0] s);
        logic [11:0] c;
        case (m)
            0:       c = s;
            1:       c = BAR[h / 2];
            2:       c = ((((h / 2) ^ (v / 2)) & 1) != 0) ? 12'hFFF : 12'h000;
            default: c = {4'(h), 4'(v * 2), 4'(f)};
        endcase
`ifdef VGA_BORDER_EN
        if (h == 0 || h == 15 || v == 0 || v == 7) c = 12'hFFF;
`endif
        return c;
    endfunction

    function automatic int ex();
        return int'(expv[22:18]);
    endfunction

    function automatic int ey();
        return int'(expv[17:14]);
    endfunction

    // One clock: applies pix_en, then updates the expected output vector from the raster model.
    task automatic advance(input logic pe);
        logic e_de, e_hs, e_vs, e_ls, e_fs;
        logic [11:0] e_c;
        pix_en = pe;
        @(posedge clk);
        cyc++;
        if (n_rst) begin
            expv = 26'h3000000;
            ph = 0; pv = 0; fc = 0; mq = 0;
        end else if (pe) begin
            e_de = (ph < 16) && (pv < 8);
            e_hs = !(ph >= 18 && ph <= 20);
            e_vs = !(pv >= 9 && pv <= 10);
            e_ls = (ph == 23);
            e_fs = e_ls && (pv == 11);
            e_c  = e_de ? exp_rgb(ph, pv, mq, fc, solid_rgb) : 12'h000;
            expv = {e_hs, e_vs, e_de, 5'(ph), 4'(pv), e_ls, e_fs, e_c};
            if (ph == 23) begin
                ph = 0;
                if (pv == 11) begin
                    pv = 0;
                    fc = (fc + 1) % 256;
                    mq = int'(mode);
                end else begin
                    pv++;
                end
            end else begin
                ph++;
            end
        end else begin
            expv[13:12] = 2'b00;
        end
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        advance(1'b1);
        n_rst = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'd0; solid_rgb = 12'h00F;
        n_rst = 1'b1;
        advance(1'b1);
        advance(1'b0);
        n_tests++;
        if (got !== 26'h3000000) begin
            n_fail++; $display("FAIL reset_vec got=%h want=%h", got, 26'h3000000);
        end
        n_tests++;
        if (hsync !== 1'b1 || vsync !== 1'b1 || de !== 1'b0) begin
            n_fail++; $display("FAIL reset_sync got hs=%b vs=%b de=%b want 1 1 0", hsync, vsync, de);
        end
        n_rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_timing();
        int last = -1, nfs = 0, hs_low = 0;
        mode = 2'd0; solid_rgb = 12'h00F;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            advance(1'b1);
            n_tests++;
            if (got !== expv) begin
                n_fail++; $display("FAIL timing cyc=%0d got=%h want=%h", cyc, got, expv);
            end
            if (ey() == 2 && hsync === 1'b0) hs_low++;
            if (ex() == 5 && ey() == 3) begin
                n_tests++;
                if ({r, g, b} !== 12'h00F) begin
                    n_fail++; $display("FAIL solid_px got=%h want=00F", {r, g, b});
                end
            end
            if (frame_start === 1'b1) begin
                nfs++;
                if (last >= 0) begin
                    n_tests++;
                    if (cyc - last != 288) begin
                        n_fail++; $display("FAIL frame_period got=%0d want=288", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        n_tests++;
        if (hs_low != 6) begin
            n_fail++; $display("FAIL hsync_width got=%0d want=6", hs_low);
        end
        n_tests++;
        if (nfs != 2) begin
            n_fail++; $display("FAIL frame_count got=%0d want=2", nfs);
        end
        $display("[TB] test_timing done");
    endtask

    task automatic test_pix_en_div4();
        int last = -1;
        mode = 2'd0; solid_rgb = 12'h00F;
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            advance((i % 4) == 0);
            n_tests++;
            if (got !== expv) begin
                n_fail++; $display("FAIL div4 cyc=%0d pe=%b got=%h want=%h", cyc, pix_en, got, expv);
            end
            if (frame_start === 1'b1) begin
                if (last >= 0) begin
                    n_tests++;
                    if (cyc - last != 1152) begin
                        n_fail++; $display("FAIL div4_period got=%0d want=1152", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        $display("[TB] test_pix_en_div4 done");
    endtask

    task automatic test_bars();
        mode = 2'd1; solid_rgb = 12'h00F;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            advance(1'b1);
            n_tests++;
            if (got !== expv) begin
                n_fail++; $display("FAIL bars cyc=%0d got=%h want=%h", cyc, got, expv);
            end
            if (i >= 288 && ex() == 4 && ey() == 1) begin
                n_tests++;
                if ({r, g, b} !== 12'h0FF) begin
                    n_fail++; $display("FAIL bar_cyan got=%h want=0FF", {r, g, b});
                end
            end
            if (i >= 288 && ex() == 14 && ey() == 2) begin
                n_tests++;
                if ({r, g, b} !== 12'h000) begin
                    n_fail++; $display("FAIL bar_black got=%h want=000", {r, g, b});
                end
            end
            if (i >= 288 && ex() == 17 && ey() == 2) begin
                n_tests++;
                if ({r, g, b} !== 12'h000 || de !== 1'b0) begin
                    n_fail++; $display("FAIL bar_blank got=%h de=%b want=000 de=0", {r, g, b}, de);
                end
            end
        end
        $display("[TB] test_bars done");
    endtask

    task automatic test_mode_switch();
        int guard = 0;
        logic seen_fs = 1'b0;
        mode = 2'd0; solid_rgb = 12'h00F;
        do_reset();
        while (ey() != 3 && guard < 400) begin
            advance(1'b1);
            guard++;
        end
        n_tests++;
        if (guard >= 400) begin
            n_fail++; $display("FAIL switch_reach got=timeout want=y3");
        end
        mode = 2'd2;
        for (int i = 0; i < 600; i++) begin
            advance(1'b1);
            if (frame_start === 1'b1) seen_fs = 1'b1;
            n_tests++;
            if (got !== expv) begin
                n_fail++; $display("FAIL switch cyc=%0d got=%h want=%h", cyc, got, expv);
            end
            if (!seen_fs && ex() == 2 && ey() == 4) begin
                n_tests++;
                if ({r, g, b} !== 12'h00F) begin
                    n_fail++; $display("FAIL switch_early got=%h want=00F", {r, g, b});
                end
            end
            if (seen_fs && ex() == 2 && ey() == 0) begin
                n_tests++;
                if ({r, g, b} !== 12'hFFF) begin
                    n_fail++; $display("FAIL chk_white got=%h want=FFF", {r, g, b});
                end
            end
            if (seen_fs && ex() == 2 && ey() == 2) begin
                n_tests++;
                if ({r, g, b} !== 12'h000) begin
                    n_fail++; $display("FAIL chk_black got=%h want=000", {r, g, b});
                end
            end
        end
        $display("[TB] test_mode_switch done");
    endtask

    task automatic test_gradient_reset();
        int nfs = 0, guard = 0;
        mode = 2'd3; solid_rgb = 12'h00F;
        do_reset();
        for (int i = 0; i < 1160; i++) begin
            advance(1'b1);
            if (frame_start === 1'b1) nfs++;
            n_tests++;
            if (got !== expv) begin
                n_fail++; $display("FAIL grad cyc=%0d got=%h want=%h", cyc, got, expv);
            end
            if (nfs >= 1 && ex() == 1 && ey() == 1) begin
                n_tests++;
                if (b !== 4'(nfs)) begin
                    n_fail++; $display("FAIL grad_b frame=%0d got=%h want=%h", nfs, b, 4'(nfs));
                end
            end
        end
        while (ey() != 5 && guard < 400) begin
            advance(1'b1);
            guard++;
        end
        n_rst = 1'b1;
        advance(1'b0);
        n_tests++;
        if (x !== 5'd0 || y !== 4'd0 || de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1 || {r, g, b} !== 12'h000) begin
            n_fail++; $display("FAIL midreset got x=%0d y=%0d de=%b hs=%b vs=%b rgb=%h want 0 0 0 1 1 000",
                               x, y, de, hsync, vsync, {r, g, b});
        end
        n_rst = 1'b0;
        nfs = 0;
        for (int i = 0; i < 320; i++) begin
            advance(1'b1);
            if (frame_start === 1'b1) nfs++;
            n_tests++;
            if (got !== expv) begin
                n_fail++; $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, got, expv);
            end
            if (nfs == 1 && ex() == 1 && ey() == 1) begin
                n_tests++;
                if (b !== 4'd1) begin
                    n_fail++; $display("FAIL post_reset_b got=%h want=1", b);
                end
            end
        end
        $display("[TB] test_gradient_reset done");
    endtask

    initial begin
        n_rst = 1'b1; pix_en = 1'b0; mode = 2'd0; solid_rgb = 12'h000;
        expv = 26'h3000000; ph = 0; pv = 0; fc = 0; mq = 0; cyc = 0;
        test_reset();
        test_timing();
        test_pix_en_div4();
        test_bars();
        test_mode_switch();
        test_gradient_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
